apb_arbiter: RTL and testbench
==============================

# apb_arbiter

Round-robin APB master that shares one APB bus (PADDR/PWRITE/PSEL/PENABLE/PWDATA/PRDATA/PREADY) between NREQ internal requesters in front of the dual-port memory slave. Each requester issues single read/write commands over a valid/ready handshake and receives a one-cycle response pulse. The block sequences the APB SETUP/ACCESS phases, honours PREADY wait states and aborts hung transfers with a timeout error.

## Interface
- NREQ, 2, number of requesters (2..4)
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables the timeout

- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  command valid per requester
- req_write  in  NREQ  1 write, 0 read
- req_addr  in  NREQ*ADDR_W  address, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  command accepted (one-hot, at most one bit high)
- rsp_valid  out  NREQ  response pulse, one-hot, one cycle
- rsp_rdata  out  DATA_W  read data, qualified by rsp_valid
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- busy  out  1  high in SETUP and ACCESS
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready

## Operation
- FSM states IDLE, SETUP, ACCESS; reset state IDLE.
- IDLE: if any req_valid, winner g = first set bit searching from (last_grant+1) mod NREQ upward with wrap. req_ready[g] driven combinationally high in IDLE only; acceptance = req_valid[g] & req_ready[g]. On accept edge: PADDR/PWRITE/PWDATA loaded from requester g, PSEL<=1, PENABLE<=0, last_grant<=g, owner<=g, state<=SETUP.
- SETUP: one cycle; PENABLE<=1, state<=ACCESS, wait counter cleared.
- ACCESS: each edge with PREADY=1 completes: PSEL<=0, PENABLE<=0, rsp_valid[owner]<=1, rsp_rdata<=PRDATA if read else 0, rsp_err<=0, state<=IDLE.
- ACCESS with PREADY=0: counter increments; when TIMEOUT!=0 and counter reaches TIMEOUT-1 with PREADY still low, transfer aborts on that edge: PSEL/PENABLE<=0, rsp_valid[owner]<=1, rsp_rdata<=0, rsp_err<=1, state<=IDLE.
- PADDR, PWRITE, PWDATA hold their last values after a transfer (no toggling while idle).
- req_ready always 0 in SETUP/ACCESS; requesters hold req_valid and fields stable until accepted.
- rsp_valid is a single-cycle pulse; no backpressure on responses.
- Counter width clog2(TIMEOUT)+1; saturates, never wraps.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, busy, rsp_err = 0; PADDR, PWDATA, rsp_rdata = 0; req_ready, rsp_valid = 0; last_grant = NREQ-1 (requester 0 wins first).
- All APB outputs, rsp_* and busy are registered; req_ready is the only combinational output.
- Accept at edge k -> PSEL high after k, PENABLE high after k+1, PREADY first sampled at k+2.
- Zero-wait transfer: rsp_valid high in cycle after edge k+2; next accept earliest at edge k+3 (3 cycles per transfer).
- Each PREADY-low cycle adds one cycle; timeout completes at ACCESS cycle TIMEOUT.
- PREADY ignored outside ACCESS.
- PRESET asserted mid-transfer: PSEL/PENABLE drop immediately (async), no response issued for the aborted command, pointer reset.
- Simultaneous requests: exactly one grant per IDLE cycle; a requester waits at most NREQ-1 transfers.

## Test plan
- Reset: PRESET pulse mid-ACCESS -> PSEL=0, PENABLE=0, rsp_valid=0 same cycle; after release, req0 and req1 both valid -> req0 granted first.
- Single write then read, PREADY tied 1: req0 write addr 0x10 data 0xDEADBEEF, then read 0x10 with PRDATA=0xDEADBEEF -> PSEL 2 cycles, PENABLE 1 cycle, rsp_valid[0] 3 cycles after accept, rsp_rdata 0xDEADBEEF, rsp_err 0.
- Wait states: PREADY low 3 ACCESS cycles -> PENABLE high 4 cycles, rsp_valid exactly once after PREADY sampled high, PADDR/PWDATA stable throughout.
- Round-robin: NREQ=2, both req_valid held high for 6 commands -> grant order 0,1,0,1,0,1; with NREQ=3 and only req0/req2 active -> 0,2,0,2.
- Timeout: TIMEOUT=16, PREADY stuck 0 -> abort on 16th ACCESS cycle, rsp_valid with rsp_err=1, rsp_rdata=0; next queued request proceeds normally.
- TIMEOUT=0, PREADY held low 100 cycles then high -> no abort, normal response with rsp_err=0.

Source files
------------

// File: rtl/apb_arbiter.sv
// Round-robin APB master: shares one APB bus between NREQ single-command requesters,
// sequencing SETUP/ACCESS, honouring PREADY wait states and aborting hung transfers.
module apb_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [ADDR_W-1:0]      PADDR,
  output logic                   PWRITE,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [DATA_W-1:0]      PRDATA,
  input  logic                   PREADY
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic [ADDR_W-1:0]  addr_arr  [NREQ];
  logic [DATA_W-1:0]  wdata_arr [NREQ];

  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  int                 cand;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // Rotating priority: search starts one past the previous winner and wraps.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last_grant_q) + off) % NREQ;
      if (!grant_found && req_valid[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    busy_d       = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          paddr_d      = addr_arr[grant_idx];
          pwrite_d     = req_write[grant_idx];
          pwdata_d     = wdata_arr[grant_idx];
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          last_grant_d = grant_idx;
          owner_d      = grant_idx;
          busy_d       = 1'b1;
          state_d      = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? '0 : PRDATA;
          rsp_err_d            = 1'b0;
          busy_d               = 1'b0;
          state_d              = ST_IDLE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          // Hung slave: terminate on the TIMEOUT-th ACCESS cycle with an error response.
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          rsp_err_d            = 1'b1;
          busy_d               = 1'b0;
          state_d              = ST_IDLE;
        end else if (!(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      owner_q      <= '0;
      cnt_q        <= '0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: a 2-requester instance with TIMEOUT=16 and a 3-requester
// instance with the timeout disabled, each fronted by a small wait-state slave model.
module tb_apb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: NREQ=2, TIMEOUT=16
  logic [1:0]  a_valid, a_write, a_ready, a_rsp_valid;
  logic [15:0] a_addr;
  logic [63:0] a_wdata;
  logic [31:0] a_rsp_rdata, a_pwdata, a_prdata;
  logic        a_rsp_err, a_busy, a_pwrite, a_psel, a_penable, a_pready;
  logic [7:0]  a_paddr;
  int          a_waits = 0;
  int          a_acc   = 0;

  // Instance B: NREQ=3, TIMEOUT=0
  logic [2:0]  b_valid, b_write, b_ready, b_rsp_valid;
  logic [23:0] b_addr;
  logic [95:0] b_wdata;
  logic [31:0] b_rsp_rdata, b_pwdata, b_prdata;
  logic        b_rsp_err, b_busy, b_pwrite, b_psel, b_penable, b_pready;
  logic [7:0]  b_paddr;
  int          b_waits = 0;
  int          b_acc   = 0;

  apb_arbiter #(.NREQ(2), .ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) u_dut_a (
    .PCLK(clk), .PRESET(rst),
    .req_valid(a_valid), .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata),
    .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .busy(a_busy), .PADDR(a_paddr), .PWRITE(a_pwrite), .PSEL(a_psel), .PENABLE(a_penable),
    .PWDATA(a_pwdata), .PRDATA(a_prdata), .PREADY(a_pready)
  );

  apb_arbiter #(.NREQ(3), .ADDR_W(8), .DATA_W(32), .TIMEOUT(0)) u_dut_b (
    .PCLK(clk), .PRESET(rst),
    .req_valid(b_valid), .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .busy(b_busy), .PADDR(b_paddr), .PWRITE(b_pwrite), .PSEL(b_psel), .PENABLE(b_penable),
    .PWDATA(b_pwdata), .PRDATA(b_prdata), .PREADY(b_pready)
  );

  // Slave models: PREADY low for the first *_waits ACCESS cycles, high otherwise
  // (including outside ACCESS, where the master must ignore it).
  initial begin
    a_pready = 1'b1;
    forever begin
      @(negedge clk);
      if (a_psel && a_penable) begin
        a_acc++;
        a_pready = (a_acc > a_waits);
      end else begin
        a_acc    = 0;
        a_pready = 1'b1;
      end
    end
  end

  initial begin
    b_pready = 1'b1;
    forever begin
      @(negedge clk);
      if (b_psel && b_penable) begin
        b_acc++;
        b_pready = (b_acc > b_waits);
      end else begin
        b_acc    = 0;
        b_pready = 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          req;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;   // negedges from accept edge to visible rsp_valid
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v);
    int n;
    int psel_n;
    int pen_n;
    bit addr_ok;
    bit wdata_ok;
    bit busy_ok;
    bit done;
    @(negedge clk);
    a_prdata                  = v.prdata;
    a_waits                   = v.waits;
    a_write[v.req]            = v.wr;
    a_addr[v.req*8 +: 8]      = v.addr;
    a_wdata[v.req*32 +: 32]   = v.wdata;
    a_valid[v.req]            = 1'b1;
    #1;
    n = 0;
    while (a_ready[v.req] !== 1'b1 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({v.name, " req_ready"}, 32'(a_ready), 32'(1 << v.req));
    @(posedge clk);
    @(negedge clk);
    a_valid[v.req] = 1'b0;
    n        = 1;
    psel_n   = 0;
    pen_n    = 0;
    addr_ok  = 1'b1;
    wdata_ok = 1'b1;
    busy_ok  = 1'b1;
    done     = 1'b0;
    while (!done && n <= 40) begin
      if (a_rsp_valid != '0) begin
        done = 1'b1;
      end else begin
        if (a_psel) begin
          psel_n++;
          if (a_paddr !== v.addr) addr_ok = 1'b0;
          if (a_pwdata !== v.wdata) wdata_ok = 1'b0;
        end
        if (a_penable) pen_n++;
        if (a_busy !== a_psel) busy_ok = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    check({v.name, " latency"},      32'(n),           32'(v.exp_lat));
    check({v.name, " rsp_valid"},    32'(a_rsp_valid), 32'(1 << v.req));
    check({v.name, " rsp_rdata"},    a_rsp_rdata,      v.exp_rdata);
    check({v.name, " rsp_err"},      32'(a_rsp_err),   32'(v.exp_err));
    check({v.name, " psel cycles"},  32'(psel_n),      32'(v.exp_lat - 1));
    check({v.name, " pen cycles"},   32'(pen_n),       32'(v.exp_lat - 2));
    check({v.name, " paddr stable"}, 32'(addr_ok),     32'd1);
    check({v.name, " pwdata stable"},32'(wdata_ok),    32'd1);
    check({v.name, " busy"},         32'(busy_ok),     32'd1);
    check({v.name, " pwrite held"},  32'(a_pwrite),    32'(v.wr));
    check({v.name, " paddr held"},   32'(a_paddr),     32'(v.addr));
    @(negedge clk);
    check({v.name, " rsp pulse"},    32'(a_rsp_valid), 32'd0);
  endtask

  // Holds a request pattern and checks the order and spacing of the responses.
  task automatic rr_a(input int cnt, input int exp_seq [6]);
    int n;
    for (int i = 0; i < cnt; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (a_rsp_valid == '0 && n < 10);
      check($sformatf("rrA grant %0d", i), 32'(a_rsp_valid), 32'(1 << exp_seq[i]));
      check($sformatf("rrA spacing %0d", i), 32'(n), 32'd3);
    end
  endtask

  task automatic rr_b(input int cnt, input int exp_seq [4]);
    int n;
    for (int i = 0; i < cnt; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (b_rsp_valid == '0 && n < 10);
      check($sformatf("rrB grant %0d", i), 32'(b_rsp_valid), 32'(1 << exp_seq[i]));
      check($sformatf("rrB spacing %0d", i), 32'(n), 32'd3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seq_a [6];
    int seq_b [4];

    a_valid = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_prdata = '0;
    b_valid = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_prdata = '0;

    vecs[0] = '{name:"wr0",   req:0, wr:1'b1, addr:8'h10, wdata:32'hDEADBEEF, prdata:32'h12345678,
                waits:0,   exp_rdata:32'h0,        exp_err:1'b0, exp_lat:3};
    vecs[1] = '{name:"rd0",   req:0, wr:1'b0, addr:8'h10, wdata:32'h00000000, prdata:32'hDEADBEEF,
                waits:0,   exp_rdata:32'hDEADBEEF, exp_err:1'b0, exp_lat:3};
    vecs[2] = '{name:"wr1w3", req:1, wr:1'b1, addr:8'h20, wdata:32'hA5A5A5A5, prdata:32'h0,
                waits:3,   exp_rdata:32'h0,        exp_err:1'b0, exp_lat:6};
    vecs[3] = '{name:"rd1w1", req:1, wr:1'b0, addr:8'hFF, wdata:32'h5A5A0000, prdata:32'h000000FF,
                waits:1,   exp_rdata:32'h000000FF, exp_err:1'b0, exp_lat:4};
    vecs[4] = '{name:"rd0w15",req:0, wr:1'b0, addr:8'h00, wdata:32'h00000001, prdata:32'hCAFEF00D,
                waits:15,  exp_rdata:32'hCAFEF00D, exp_err:1'b0, exp_lat:18};
    vecs[5] = '{name:"rd1to", req:1, wr:1'b0, addr:8'h44, wdata:32'h00000002, prdata:32'h11112222,
                waits:16,  exp_rdata:32'h0,        exp_err:1'b1, exp_lat:18};
    vecs[6] = '{name:"rd0aft",req:0, wr:1'b0, addr:8'h55, wdata:32'h00000003, prdata:32'h33334444,
                waits:0,   exp_rdata:32'h33334444, exp_err:1'b0, exp_lat:3};

    // Reset values while PRESET is held
    #23;
    check("rst psel",      32'(a_psel),      32'd0);
    check("rst penable",   32'(a_penable),   32'd0);
    check("rst pwrite",    32'(a_pwrite),    32'd0);
    check("rst busy",      32'(a_busy),      32'd0);
    check("rst rsp_err",   32'(a_rsp_err),   32'd0);
    check("rst paddr",     32'(a_paddr),     32'd0);
    check("rst pwdata",    a_pwdata,         32'd0);
    check("rst rsp_rdata", a_rsp_rdata,      32'd0);
    check("rst rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst req_ready", 32'(a_ready),     32'd0);
    check("rst B psel",    32'(b_psel),      32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a hung ACCESS phase
    @(negedge clk);
    a_waits   = 1000;
    a_write[1] = 1'b0;
    a_addr[15:8] = 8'h77;
    a_valid[1] = 1'b1;
    #1;
    n = 0;
    while (a_ready[1] !== 1'b1 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("mid req_ready", 32'(a_ready), 32'b10);
    @(posedge clk);
    @(negedge clk);
    a_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid pre psel",    32'(a_psel),    32'd1);
    check("mid pre penable", 32'(a_penable), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid async psel",      32'(a_psel),      32'd0);
    check("mid async penable",   32'(a_penable),   32'd0);
    check("mid async rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("mid async busy",      32'(a_busy),      32'd0);
    @(negedge clk);
    rst     = 1'b0;
    a_waits = 0;

    // After release both requesters valid: requester 0 wins first, then strict alternation
    a_write  = 2'b00;
    a_prdata = 32'h0000BEEF;
    a_valid  = 2'b11;
    #1;
    check("post-reset first ready", 32'(a_ready), 32'b01);
    seq_a = '{0, 1, 0, 1, 0, 1};
    rr_a(6, seq_a);
    a_valid = 2'b00;
    @(negedge clk);
    check("rrA drained", 32'(a_busy), 32'd0);

    // NREQ=3, only requesters 0 and 2 active
    b_write  = 3'b000;
    b_prdata = 32'h00C0FFEE;
    b_waits  = 0;
    b_valid  = 3'b101;
    seq_b = '{0, 2, 0, 2};
    rr_b(4, seq_b);
    b_valid = 3'b000;

    // TIMEOUT=0: 100 wait cycles must not abort
    @(negedge clk);
    b_waits       = 100;
    b_prdata      = 32'h0BADCAFE;
    b_write[1]    = 1'b0;
    b_addr[15:8]  = 8'h3C;
    b_valid[1]    = 1'b1;
    #1;
    n = 0;
    while (b_ready[1] !== 1'b1 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("noto req_ready", 32'(b_ready), 32'b010);
    @(posedge clk);
    @(negedge clk);
    b_valid[1] = 1'b0;
    n = 1;
    while (b_rsp_valid == '0 && n <= 200) begin
      @(negedge clk);
      n++;
    end
    check("noto latency",   32'(n),           32'd103);
    check("noto rsp_valid", 32'(b_rsp_valid), 32'b010);
    check("noto rsp_rdata", b_rsp_rdata,      32'h0BADCAFE);
    check("noto rsp_err",   32'(b_rsp_err),   32'd0);
    check("noto paddr",     32'(b_paddr),     32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
